// File: rtl/change_dispenser.sv
// change_dispenser: turns each owed-change event from the vending FSM into a
// stream of 10- and 5-unit coins for the hopper. The largest coin the stock
// allows goes first. The block keeps a count of each coin type and reports a
// shortfall when it runs out. One request can wait in a pending slot while
// another is being paid out.
module change_dispenser #(
    parameter int STOCK_W      = 8,
    parameter int STOCK5_INIT  = 20,
    parameter int STOCK10_INIT = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vend_valid,
    input  logic [2:0]         change,
    input  logic               refill,
    input  logic               coin_ready,
    output logic               coin_valid,
    output logic               coin_type,
    output logic               busy,
    output logic               done,
    output logic               short_err,
    output logic [2:0]         owed,
    output logic               overflow,
    output logic [STOCK_W-1:0] stock5,
    output logic [STOCK_W-1:0] stock10
);

    localparam logic [STOCK_W-1:0] S5_INIT  = STOCK_W'(STOCK5_INIT);
    localparam logic [STOCK_W-1:0] S10_INIT = STOCK_W'(STOCK10_INIT);
    localparam logic [STOCK_W-1:0] ONE      = STOCK_W'(1);

    typedef enum logic {
        IDLE,
        DISPENSE
    } state_t;

    state_t             state, state_next;
    logic [2:0]         rem, rem_next;
    logic               pend_valid, pend_valid_next;
    logic [2:0]         pend_change, pend_change_next;
    logic [STOCK_W-1:0] stock5_next, stock10_next;
    logic               done_next, short_next, overflow_next;
    logic [2:0]         owed_next;
    logic               use_ten, coin_avail;
    logic               src_valid;
    logic [2:0]         src_change;

    // Register the state, the remainder, the pending slot, the stocks and the pulse outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            rem         <= 3'd0;
            pend_valid  <= 1'b0;
            pend_change <= 3'd0;
            stock5      <= S5_INIT;
            stock10     <= S10_INIT;
            done        <= 1'b0;
            short_err   <= 1'b0;
            overflow    <= 1'b0;
            owed        <= 3'd0;
        end else begin
            state       <= state_next;
            rem         <= rem_next;
            pend_valid  <= pend_valid_next;
            pend_change <= pend_change_next;
            stock5      <= stock5_next;
            stock10     <= stock10_next;
            done        <= done_next;
            short_err   <= short_next;
            overflow    <= overflow_next;
            owed        <= owed_next;
        end
    end

    // Next-state logic: pick a request source, take coins out of stock on each handshake, queue or drop new requests
    always_comb begin
        state_next       = state;
        rem_next         = rem;
        pend_valid_next  = pend_valid;
        pend_change_next = pend_change;
        stock5_next      = stock5;
        stock10_next     = stock10;
        done_next        = 1'b0;
        short_next       = 1'b0;
        overflow_next    = 1'b0;
        owed_next        = owed;
        src_valid        = 1'b0;
        src_change       = 3'd0;
        case (state)
            IDLE: begin
                if (refill) begin
                    stock5_next  = S5_INIT;
                    stock10_next = S10_INIT;
                end
                if (pend_valid) begin
                    src_valid       = 1'b1;
                    src_change      = pend_change;
                    pend_valid_next = vend_valid;
                    if (vend_valid) begin
                        pend_change_next = change;
                    end
                end else begin
                    src_valid  = vend_valid;
                    src_change = change;
                end
                if (src_valid) begin
                    if (src_change == 3'd0) begin
                        done_next = 1'b1;
                    end else begin
                        rem_next   = src_change;
                        state_next = DISPENSE;
                    end
                end
            end
            DISPENSE: begin
                if (vend_valid) begin
                    if (pend_valid) begin
                        overflow_next = 1'b1;
                    end else begin
                        pend_valid_next  = 1'b1;
                        pend_change_next = change;
                    end
                end
                if (!coin_avail) begin
                    state_next = IDLE;
                    short_next = 1'b1;
                    owed_next  = rem;
                end else if (coin_ready) begin
                    if (use_ten) begin
                        rem_next     = rem - 3'd2;
                        stock10_next = stock10 - ONE;
                    end else begin
                        rem_next    = rem - 3'd1;
                        stock5_next = stock5 - ONE;
                    end
                    if (rem_next == 3'd0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Coin presentation depends only on registered state, so it stays stable while the hopper stalls
    always_comb begin
        use_ten    = (rem >= 3'd2) && (stock10 != '0);
        coin_avail = use_ten || (stock5 != '0);
        busy       = (state == DISPENSE);
        coin_valid = busy && coin_avail;
        coin_type  = busy && use_ten;
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed scenarios with constant expectations, then a
// long randomized run checked every cycle against a behavioural payout model.
module tb_change_dispenser;

    localparam int STOCK_W = 8;
    localparam int S5I     = 20;
    localparam int S10I    = 20;

    logic               clk = 1'b0;
    logic               rst;
    logic               vend_valid;
    logic [2:0]         change;
    logic               refill;
    logic               coin_ready;
    logic               coin_valid;
    logic               coin_type;
    logic               busy;
    logic               done;
    logic               short_err;
    logic [2:0]         owed;
    logic               overflow;
    logic [STOCK_W-1:0] stock5;
    logic [STOCK_W-1:0] stock10;

    int checks = 0;
    int errors = 0;

    // behavioural model state for the randomized run
    int m_busy, m_rem, m_pv, m_pc, m_s5, m_s10, m_done, m_short, m_ovf, m_owed;

    change_dispenser #(
        .STOCK_W(STOCK_W),
        .STOCK5_INIT(S5I),
        .STOCK10_INIT(S10I)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vend_valid(vend_valid),
        .change(change),
        .refill(refill),
        .coin_ready(coin_ready),
        .coin_valid(coin_valid),
        .coin_type(coin_type),
        .busy(busy),
        .done(done),
        .short_err(short_err),
        .owed(owed),
        .overflow(overflow),
        .stock5(stock5),
        .stock10(stock10)
    );

    // free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst        = 1'b0;
        vend_valid = 1'b0;
        change     = 3'd0;
        refill     = 1'b0;
        coin_ready = 1'b0;
        tick;
        tick;
        rst = 1'b1;
    endtask

    // Pulse one request with the hopper always ready, then wait for done or short_err.
    task automatic run_request(input logic [2:0] chg, output int coins,
                               output bit got_done, output bit got_short);
        coins      = 0;
        got_done   = 1'b0;
        got_short  = 1'b0;
        coin_ready = 1'b1;
        vend_valid = 1'b1;
        change     = chg;
        tick;
        vend_valid = 1'b0;
        for (int i = 0; i < 60 && !got_done && !got_short; i++) begin
            if (done === 1'b1) begin
                got_done = 1'b1;
            end else if (short_err === 1'b1) begin
                got_short = 1'b1;
            end else begin
                if (coin_valid === 1'b1) coins++;
                tick;
            end
        end
        checks++;
        if (!(got_done || got_short)) begin
            errors++;
            $display("[TB] FAIL request_timeout change=%0d got no done/short_err want one within 60 cycles", chg);
        end
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (coin_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_coin_valid got %b want 0", coin_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0 || short_err !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses got %b%b%b want 000", done, short_err, overflow); end
        checks++; if (owed !== 3'd0) begin errors++; $display("[TB] FAIL reset_owed got %0d want 0", owed); end
        checks++; if (stock5 !== 8'd20) begin errors++; $display("[TB] FAIL reset_stock5 got %0d want 20", stock5); end
        checks++; if (stock10 !== 8'd20) begin errors++; $display("[TB] FAIL reset_stock10 got %0d want 20", stock10); end
    endtask

    task automatic test_basic;
        do_reset;
        // zero change: immediate done, nothing dispensed
        vend_valid = 1'b1; change = 3'd0; coin_ready = 1'b1;
        tick;
        vend_valid = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_change got done=%b busy=%b want done=1 busy=0", done, busy); end
        tick;
        // change=3 pays 10 then 5
        vend_valid = 1'b1; change = 3'd3;
        tick;
        vend_valid = 1'b0;
        checks++; if (coin_valid !== 1'b1 || coin_type !== 1'b1) begin errors++; $display("[TB] FAIL basic_first_coin got v=%b t=%b want v=1 t=1", coin_valid, coin_type); end
        tick;
        checks++; if (coin_valid !== 1'b1 || coin_type !== 1'b0) begin errors++; $display("[TB] FAIL basic_second_coin got v=%b t=%b want v=1 t=0", coin_valid, coin_type); end
        tick;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || coin_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_done got done=%b busy=%b v=%b want 1 0 0", done, busy, coin_valid); end
        checks++; if (stock10 !== 8'd19 || stock5 !== 8'd19) begin errors++; $display("[TB] FAIL basic_stocks got s10=%0d s5=%0d want 19 19", stock10, stock5); end
        tick;
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse got %b want 0", done); end
    endtask

    task automatic test_stall;
        do_reset;
        vend_valid = 1'b1; change = 3'd4; coin_ready = 1'b0;
        tick;
        vend_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (coin_valid !== 1'b1 || coin_type !== 1'b1) begin errors++; $display("[TB] FAIL stall_hold cycle=%0d got v=%b t=%b want v=1 t=1", i, coin_valid, coin_type); end
            tick;
        end
        coin_ready = 1'b1;
        checks++; if (coin_valid !== 1'b1 || coin_type !== 1'b1) begin errors++; $display("[TB] FAIL stall_release got v=%b t=%b want v=1 t=1", coin_valid, coin_type); end
        tick;
        checks++; if (coin_valid !== 1'b1 || coin_type !== 1'b1) begin errors++; $display("[TB] FAIL stall_second_ten got v=%b t=%b want v=1 t=1", coin_valid, coin_type); end
        tick;
        checks++; if (done !== 1'b1 || stock10 !== 8'd18 || stock5 !== 8'd20) begin errors++; $display("[TB] FAIL stall_done got done=%b s10=%0d s5=%0d want 1 18 20", done, stock10, stock5); end
    endtask

    task automatic test_drain_and_short;
        int  coins;
        bit  gd, gs;
        do_reset;
        // ten requests of 20 units empty the 10-unit stock exactly
        for (int i = 0; i < 10; i++) begin
            run_request(3'd4, coins, gd, gs);
            checks++; if (coins !== 2 || !gd) begin errors++; $display("[TB] FAIL drain_ten req=%0d got coins=%0d done=%b want 2 1", i, coins, gd); end
        end
        checks++; if (stock10 !== 8'd0 || stock5 !== 8'd20) begin errors++; $display("[TB] FAIL drain_ten_stocks got s10=%0d s5=%0d want 0 20", stock10, stock5); end
        // with no 10s left, 25 units are five 5-unit coins
        run_request(3'd5, coins, gd, gs);
        checks++; if (coins !== 5 || !gd || stock5 !== 8'd15) begin errors++; $display("[TB] FAIL fives_only got coins=%0d done=%b s5=%0d want 5 1 15", coins, gd, stock5); end
        run_request(3'd7, coins, gd, gs);
        run_request(3'd7, coins, gd, gs);
        checks++; if (coins !== 7 || !gd || stock5 !== 8'd1) begin errors++; $display("[TB] FAIL drain_five got coins=%0d done=%b s5=%0d want 7 1 1", coins, gd, stock5); end
        // 15 owed, one 5 available: pays one coin, then short with 10 (2 units) owed
        run_request(3'd3, coins, gd, gs);
        checks++; if (coins !== 1 || !gs || gd) begin errors++; $display("[TB] FAIL short_event got coins=%0d short=%b done=%b want 1 1 0", coins, gs, gd); end
        checks++; if (owed !== 3'd2 || busy !== 1'b0) begin errors++; $display("[TB] FAIL short_owed got owed=%0d busy=%b want 2 0", owed, busy); end
        checks++; if (stock5 !== 8'd0 || stock10 !== 8'd0) begin errors++; $display("[TB] FAIL short_stocks got s5=%0d s10=%0d want 0 0", stock5, stock10); end
        tick;
        checks++; if (short_err !== 1'b0 || owed !== 3'd2 || coin_valid !== 1'b0) begin errors++; $display("[TB] FAIL short_after got short=%b owed=%0d v=%b want 0 2 0", short_err, owed, coin_valid); end
    endtask

    task automatic test_pending;
        int hs, dones, ovfs;
        bit types[$];
        do_reset;
        coin_ready = 1'b0;
        vend_valid = 1'b1; change = 3'd2;
        tick;
        change = 3'd1;
        tick;
        change = 3'd2;
        tick;
        vend_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL overflow_pulse got %b want 1", overflow); end
        coin_ready = 1'b1;
        hs = 0; dones = 0; ovfs = 0;
        for (int i = 0; i < 15; i++) begin
            if (coin_valid === 1'b1) begin hs++; types.push_back(coin_type); end
            if (done === 1'b1) dones++;
            if (i > 0 && overflow === 1'b1) ovfs++;
            tick;
        end
        // 10 for the first request, 5 for the queued one; the third was dropped
        checks++; if (hs !== 2 || dones !== 2) begin errors++; $display("[TB] FAIL pending_count got handshakes=%0d dones=%0d want 2 2", hs, dones); end
        checks++; if (types.size() != 2 || types[0] !== 1'b1 || types[1] !== 1'b0) begin errors++; $display("[TB] FAIL pending_types got n=%0d want 10 then 5", types.size()); end
        checks++; if (ovfs !== 0 || stock10 !== 8'd19 || stock5 !== 8'd19) begin errors++; $display("[TB] FAIL pending_end got ovf=%0d s10=%0d s5=%0d want 0 19 19", ovfs, stock10, stock5); end
    endtask

    task automatic test_refill_and_reset;
        int coins;
        bit gd, gs;
        do_reset;
        run_request(3'd3, coins, gd, gs);
        tick;
        // refill together with a request in IDLE: refilled stock is used
        vend_valid = 1'b1; change = 3'd2; refill = 1'b1;
        tick;
        vend_valid = 1'b0; refill = 1'b0;
        tick;
        checks++; if (done !== 1'b1 || stock10 !== 8'd19 || stock5 !== 8'd20) begin errors++; $display("[TB] FAIL refill_with_req got done=%b s10=%0d s5=%0d want 1 19 20", done, stock10, stock5); end
        // refill while dispensing is ignored
        coin_ready = 1'b0;
        vend_valid = 1'b1; change = 3'd6;
        tick;
        vend_valid = 1'b0; refill = 1'b1;
        tick;
        refill = 1'b0;
        checks++; if (busy !== 1'b1 || stock10 !== 8'd19 || stock5 !== 8'd20) begin errors++; $display("[TB] FAIL refill_ignored got busy=%b s10=%0d s5=%0d want 1 19 20", busy, stock10, stock5); end
        coin_ready = 1'b1;
        tick;
        checks++; if (coin_valid !== 1'b1 || stock10 !== 8'd18) begin errors++; $display("[TB] FAIL mid_handshake got v=%b s10=%0d want 1 18", coin_valid, stock10); end
        // reset in the middle of a payout
        rst = 1'b0;
        tick;
        checks++; if (coin_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_outputs got v=%b busy=%b done=%b want 0 0 0", coin_valid, busy, done); end
        checks++; if (stock10 !== 8'd20 || stock5 !== 8'd20) begin errors++; $display("[TB] FAIL mid_reset_stocks got s10=%0d s5=%0d want 20 20", stock10, stock5); end
        rst = 1'b1;
        coin_ready = 1'b0;
    endtask

    // Payout model: greedy largest coin from stock, one pending request, refill only while idle.
    task automatic model_step;
        int src;
        bit have, ten, avail;
        if (!rst) begin
            m_busy = 0; m_rem = 0; m_pv = 0; m_pc = 0;
            m_s5 = S5I; m_s10 = S10I;
            m_done = 0; m_short = 0; m_ovf = 0; m_owed = 0;
        end else begin
            m_done = 0; m_short = 0; m_ovf = 0;
            if (m_busy == 0) begin
                if (refill) begin m_s5 = S5I; m_s10 = S10I; end
                have = (m_pv != 0) || vend_valid;
                src  = (m_pv != 0) ? m_pc : int'(change);
                if (m_pv != 0) begin
                    m_pv = vend_valid ? 1 : 0;
                    if (vend_valid) m_pc = int'(change);
                end
                if (have) begin
                    if (src == 0) m_done = 1;
                    else begin m_busy = 1; m_rem = src; end
                end
            end else begin
                ten   = (m_rem >= 2) && (m_s10 > 0);
                avail = ten || (m_s5 > 0);
                if (vend_valid) begin
                    if (m_pv != 0) m_ovf = 1;
                    else begin m_pv = 1; m_pc = int'(change); end
                end
                if (!avail) begin
                    m_busy = 0; m_short = 1; m_owed = m_rem;
                end else if (coin_ready) begin
                    if (ten) begin m_rem -= 2; m_s10--; end
                    else begin m_rem -= 1; m_s5--; end
                    if (m_rem == 0) begin m_busy = 0; m_done = 1; end
                end
            end
        end
    endtask

    task automatic test_random;
        bit exp_valid, exp_type;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst        = (cyc == 0 || $urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            vend_valid = ($urandom_range(0, 4) == 0);
            change     = 3'($urandom_range(0, 7));
            refill     = ($urandom_range(0, 59) == 0);
            coin_ready = ($urandom_range(0, 9) < 7);
            model_step;
            tick;
            exp_type  = (m_busy != 0) && (m_rem >= 2) && (m_s10 > 0);
            exp_valid = (m_busy != 0) && (exp_type || (m_s5 > 0));
            checks++; if (coin_valid !== exp_valid || busy !== 1'(m_busy)) begin errors++; $display("[TB] FAIL rand_valid cyc=%0d got v=%b busy=%b want v=%b busy=%0d", cyc, coin_valid, busy, exp_valid, m_busy); end
            if (exp_valid) begin
                checks++; if (coin_type !== exp_type) begin errors++; $display("[TB] FAIL rand_type cyc=%0d got %b want %b", cyc, coin_type, exp_type); end
            end
            checks++; if (done !== 1'(m_done) || short_err !== 1'(m_short) || overflow !== 1'(m_ovf)) begin errors++; $display("[TB] FAIL rand_pulses cyc=%0d got d=%b s=%b o=%b want %0d %0d %0d", cyc, done, short_err, overflow, m_done, m_short, m_ovf); end
            checks++; if (owed !== 3'(m_owed)) begin errors++; $display("[TB] FAIL rand_owed cyc=%0d got %0d want %0d", cyc, owed, m_owed); end
            checks++; if (stock5 !== 8'(m_s5) || stock10 !== 8'(m_s10)) begin errors++; $display("[TB] FAIL rand_stocks cyc=%0d got s5=%0d s10=%0d want %0d %0d", cyc, stock5, stock10, m_s5, m_s10); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_drain_and_short;
        test_pending;
        test_refill_and_reset;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
